multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
- Multicycle control FSM for the LEGv8 subset core: LDUR, STUR, CBZ, ADD, SUB, AND, ORR.
- Replaces single-cycle main decoding; sequences a shared instruction/data memory, ALU, register file and PC over several cycles per instruction.
- Handles variable-latency memory through a req/ack handshake and flags illegal opcodes and memory timeouts.

Parameters:
- CNT_W, 16, width of retired-instruction counter.
- TIMEOUT, 255, max cycles to wait for mem_ack before faulting (1..2^16-1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- run  in  1  allow new instruction fetch.
- Op  in  11  instruction opcode field from IR (IR[31:21]).
- zero  in  1  ALU zero flag.
- mem_ack  in  1  memory completes the current access this cycle.
- mem_read  out  1  memory read request.
- mem_write  out  1  memory write request.
- iord  out  1  memory address select: 0=PC, 1=ALU result.
- ir_write  out  1  load IR.
- pc_write  out  1  load PC.
- pc_src  out  1  PC source: 0=PC+4, 1=branch target.
- reg2loc  out  1  read register 2 select: 1=Rt.
- alu_src  out  1  ALU B operand: 1=sign-extended immediate.
- alu_op  out  2  00 add, 01 pass-B/CBZ, 10 funct-decoded.
- reg_write  out  1  register file write enable.
- mem_to_reg  out  1  write-back source: 1=memory.
- retire  out  1  one-cycle pulse per completed instruction.
- retired_cnt  out  CNT_W  retired instructions, wraps.
- fault  out  2  00 none, 01 illegal opcode, 10 memory timeout; sticky.

Behaviour:
- Single clock; reset is synchronous and active-high. Reset sets state=FETCH, wait_cnt=0, retired_cnt=0, fault=00. Reset overrides everything, mid-access included; a pending request drops the next cycle.
- Unlisted outputs are 0 in every state. With state=FETCH and run=0, all control outputs are 0.
- Outputs are Moore from state, except ir_write/pc_write (qualified by mem_ack) and pc_write in BRANCH (qualified by zero).
- FETCH: if run=1, assert mem_read, iord=0. On mem_ack, pulse ir_write=1 and pc_write=1 (pc_src=0), then go to DECODE. mem_ack in the first cycle is legal (zero wait).
- DECODE: alu_src=0. Op match (? = don't care):
  - 11111000010 → ADDR_L
  - 11111000000 → ADDR_S
  - 10110100??? → BRANCH
  - 10001011000, 11001011000, 10001010000, 10101010000 → EXEC_R
  - anything else → FAULT with fault=01
- EXEC_R: alu_op=10, alu_src=0 → WB_R.
- WB_R: reg_write=1, mem_to_reg=0, alu_op=10. Retire, then FETCH.
- ADDR_L / ADDR_S: alu_src=1, alu_op=00 → MEM_RD / MEM_WR. ADDR_S also drives reg2loc=1.
- MEM_RD: mem_read=1, iord=1, alu_src=1. On mem_ack → WB_M.
- WB_M: reg_write=1, mem_to_reg=1. Retire, then FETCH.
- MEM_WR: mem_write=1, iord=1, reg2loc=1, alu_src=1. On mem_ack, retire, then FETCH.
- BRANCH: reg2loc=1, alu_op=01, pc_src=1, pc_write=zero. Retire, then FETCH.
- Latency with zero-wait memory: R-type 4 cycles, LDUR 5, STUR 4, CBZ 3 (FETCH through last state).
- Retire: retire=1 in the final cycle of the instruction; retired_cnt increments the same edge and wraps from 2^CNT_W-1 to 0.
- Timeout:
  - wait_cnt clears on entering FETCH/MEM_RD/MEM_WR and increments each request cycle without mem_ack.
  - If wait_cnt reaches TIMEOUT with still no ack → FAULT, fault=10.
  - In FETCH the count only runs while run=1.
- run deasserting mid-instruction has no effect; it is sampled only in FETCH before a request is issued. Once mem_read is issued in FETCH, the request holds until ack or timeout regardless of run.
- FAULT: all control outputs 0, no retire, held until reset.
- mem_read and mem_write are never both 1.

Test Plan:
- Reset, run=1, Op=10001011000 (ADD), mem_ack=1 always → states FETCH, DECODE, EXEC_R, WB_R; reg_write=1 in cycle 4 only; retire pulse; retired_cnt=1.
- LDUR (11111000010), fetch ack immediate, data ack after 3 wait cycles → MEM_RD held 4 cycles with iord=1; WB_M has mem_to_reg=1; total 8 cycles.
- CBZ (10110100101) with zero=1 then zero=0 → pc_write=1/pc_src=1 in BRANCH first time; pc_write=0 second time; retired_cnt=2.
- Op=11111111111 → fault=01 after DECODE; outputs 0 for 20 cycles; reset clears fault to 00.
- TIMEOUT=4, STUR with mem_ack never asserted in MEM_WR → fault=10 after 4 wait cycles; mem_write drops; retired_cnt unchanged.
- CNT_W=2, four back-to-back ADDs → retired_cnt 1,2,3,0; reset asserted during MEM_RD → next cycle FETCH with mem_read=run.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: sequences fetch, decode, execute, memory and write-back; 3-5 cycles per instruction.
// Memory stalls hold the current state until mem_ack; a wait past TIMEOUT or an illegal opcode latches a sticky fault.
module multicycle_ctrl #(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [10:0]      Op,
  input  logic             zero,
  input  logic             mem_ack,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             reg2loc,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             retire,
  output logic [CNT_W-1:0] retired_cnt,
  output logic [1:0]       fault
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_ADDR_L, S_ADDR_S,
    S_MEM_RD, S_WB_M, S_MEM_WR, S_BRANCH, S_FAULT
  } state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic             fetch_req_q, fetch_req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       fault_q, fault_d;
  logic             waiting;

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    fetch_req_d = fetch_req_q;
    cnt_d       = cnt_q;
    fault_d     = fault_q;
    waiting     = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_src      = 1'b0;
    reg2loc     = 1'b0;
    alu_src     = 1'b0;
    alu_op      = 2'b00;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    retire      = 1'b0;

    case (state_q)
      S_FETCH: begin
        // run only gates issuing the request; an issued fetch is held until ack or timeout
        if (run || fetch_req_q) begin
          mem_read = 1'b1;
          if (mem_ack) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end else begin
            waiting     = 1'b1;
            fetch_req_d = 1'b1;
          end
        end
      end
      S_DECODE: begin
        casez (Op)
          11'b11111000010: state_d = S_ADDR_L;
          11'b11111000000: state_d = S_ADDR_S;
          11'b10110100???: state_d = S_BRANCH;
          11'b10001011000,
          11'b11001011000,
          11'b10001010000,
          11'b10101010000: state_d = S_EXEC_R;
          default: begin
            state_d = S_FAULT;
            fault_d = 2'b01;
          end
        endcase
      end
      S_EXEC_R: begin
        alu_op  = 2'b10;
        state_d = S_WB_R;
      end
      S_WB_R: begin
        reg_write = 1'b1;
        alu_op    = 2'b10;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_ADDR_L: begin
        alu_src = 1'b1;
        state_d = S_MEM_RD;
      end
      S_ADDR_S: begin
        alu_src = 1'b1;
        reg2loc = 1'b1;
        state_d = S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        alu_src  = 1'b1;
        if (mem_ack) state_d = S_WB_M;
        else         waiting = 1'b1;
      end
      S_WB_M: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        reg2loc   = 1'b1;
        alu_src   = 1'b1;
        if (mem_ack) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          waiting = 1'b1;
        end
      end
      S_BRANCH: begin
        reg2loc  = 1'b1;
        alu_op   = 2'b01;
        pc_src   = 1'b1;
        pc_write = zero;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: state_d = S_FETCH;
    endcase

    // The TIMEOUT-th consecutive unacknowledged request cycle faults instead of waiting again
    if (waiting) begin
      if (wait_cnt_q >= TO_LAST) begin
        state_d = S_FAULT;
        fault_d = 2'b10;
      end else begin
        wait_cnt_d = wait_cnt_q + 16'd1;
      end
    end

    if (state_d != state_q) begin
      wait_cnt_d  = 16'd0;
      fetch_req_d = 1'b0;
    end

    if (retire) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      wait_cnt_q  <= 16'd0;
      fetch_req_q <= 1'b0;
      cnt_q       <= '0;
      fault_q     <= 2'b00;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      fetch_req_q <= fetch_req_d;
      cnt_q       <= cnt_d;
      fault_q     <= fault_d;
    end
  end

  assign retired_cnt = cnt_q;
  assign fault       = fault_q;

endmodule
